// File: rtl/dmem_responder.sv
// Load/store data-port responder: one request in flight, fixed-latency reply from
// word-organised storage, byte/half/word access with sign/zero extension on loads.
module dmem_responder #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned LATENCY     = 2,
   parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int unsigned IW   = $clog2(DEPTH_WORDS);
   localparam logic [31:0] SPAN = 32'(DEPTH_WORDS * 4);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WAIT = 2'd1;
   localparam logic [1:0] S_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic [31:0]   off;
   logic          in_range;
   logic [1:0]    lane;
   logic [IW-1:0] idx;
   logic          err;
   logic [3:0]    be;
   logic [31:0]   rd_word;
   logic [31:0]   shifted;
   logic [31:0]   ext;
   logic [31:0]   wdata_lane;
   logic          wr_en;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      we_d      = we_q;
      addr_d    = addr_q;
      size_d    = size_q;
      uns_d     = uns_q;
      wdata_d   = wdata_q;
      req_ready = (state_q == S_IDLE);
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               we_d    = req_we;
               addr_d  = req_addr;
               size_d  = req_size;
               uns_d   = req_unsigned;
               wdata_d = req_wdata;
               if (LATENCY == 1) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(LATENCY - 2);
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = S_RESP;
            else               cnt_d   = cnt_q - 4'd1;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Decode works on the latched request; the offset compare is 32-bit so addresses
   // past the top of storage never wrap back into it.
   always_comb begin
      off      = addr_q - BASE_ADDR;
      in_range = (addr_q >= BASE_ADDR) && (off < SPAN);
      lane     = off[1:0];
      idx      = off[IW+1:2];
      err      = !in_range || (size_q == 2'd3) ||
                 ((size_q == 2'd1) && lane[0]) ||
                 ((size_q == 2'd2) && (lane != 2'd0));
      case (size_q)
         2'd0:    be = 4'b0001 << lane;
         2'd1:    be = 4'b0011 << lane;
         2'd2:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      rd_word    = mem[idx];
      shifted    = rd_word >> {lane, 3'b000};
      wdata_lane = wdata_q << {lane, 3'b000};
      case (size_q)
         2'd0:    ext = {{24{~uns_q & shifted[7]}},  shifted[7:0]};
         2'd1:    ext = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
         default: ext = shifted;
      endcase
   end

   // Reset in the RESP cycle must hide the response and block the write.
   assign resp_valid = (state_q == S_RESP) && !reset;
   assign resp_err   = resp_valid && err;
   assign resp_rdata = (resp_valid && !we_q && !err) ? ext : '0;
   assign stall      = req_valid && !resp_valid;
   assign wr_en      = resp_valid && we_q && !err;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         size_q  <= '0;
         uns_q   <= 1'b0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         size_q  <= size_d;
         uns_q   <= uns_d;
         wdata_q <= wdata_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int unsigned b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wdata_lane[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: three instances (LATENCY 2/4/1) checked
// against a byte-array reference model with directed and randomized accesses.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset        [3];
   logic        req_valid    [3];
   logic        req_we       [3];
   logic [31:0] req_addr     [3];
   logic [1:0]  req_size     [3];
   logic        req_unsigned [3];
   logic [31:0] req_wdata    [3];
   logic        req_ready    [3];
   logic        resp_valid   [3];
   logic [31:0] resp_rdata   [3];
   logic        resp_err     [3];
   logic        stall        [3];

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [7:0]  mdl [3][1024];
   logic [31:0] base_of [3] = '{32'h0, 32'h0, 32'h1000};
   int          lat_of  [3] = '{2, 4, 1};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(32'h0)) u0 (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_we(req_we[0]),
      .req_addr(req_addr[0]), .req_size(req_size[0]), .req_unsigned(req_unsigned[0]),
      .req_wdata(req_wdata[0]), .req_ready(req_ready[0]), .resp_valid(resp_valid[0]),
      .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]), .stall(stall[0]));

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(32'h0)) u1 (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_we(req_we[1]),
      .req_addr(req_addr[1]), .req_size(req_size[1]), .req_unsigned(req_unsigned[1]),
      .req_wdata(req_wdata[1]), .req_ready(req_ready[1]), .resp_valid(resp_valid[1]),
      .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]), .stall(stall[1]));

   dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h1000)) u2 (
      .clk(clk), .reset(reset[2]), .req_valid(req_valid[2]), .req_we(req_we[2]),
      .req_addr(req_addr[2]), .req_size(req_size[2]), .req_unsigned(req_unsigned[2]),
      .req_wdata(req_wdata[2]), .req_ready(req_ready[2]), .resp_valid(resp_valid[2]),
      .resp_rdata(resp_rdata[2]), .resp_err(resp_err[2]), .stall(stall[2]));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Reference: storage is a flat byte array, an access touches 2**size bytes.
   task automatic model_op(input int k, input bit we, input logic [31:0] addr,
                           input logic [1:0] size, input bit uns, input logic [31:0] wd,
                           output logic [31:0] rd, output bit er);
      logic [31:0] off;
      int n;
      off = addr - base_of[k];
      n   = 1 << size;
      er  = (size == 2'd3) || (addr < base_of[k]) || (off >= 32'd1024) || (off % n != 0);
      rd  = '0;
      if (!er) begin
         if (we) begin
            for (int i = 0; i < n; i++) mdl[k][off + i] = wd[8*i +: 8];
         end else begin
            for (int i = 0; i < n; i++) rd[8*i +: 8] = mdl[k][off + i];
            if (!uns && n < 4 && rd[8*n-1])
               for (int i = n; i < 4; i++) rd[8*i +: 8] = 8'hFF;
         end
      end
   endtask

   task automatic drive(input int k, input bit we, input logic [31:0] addr,
                        input logic [1:0] size, input bit uns, input logic [31:0] wd);
      req_valid[k]    = 1'b1;
      req_we[k]       = we;
      req_addr[k]     = addr;
      req_size[k]     = size;
      req_unsigned[k] = uns;
      req_wdata[k]    = wd;
   endtask

   task automatic xact(input int k, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input bit uns, input logic [31:0] wd,
                       input bit hold, input bit drop,
                       output logic [31:0] rd, output bit er, output int acc, output int rsp);
      int t;
      @(negedge clk);
      drive(k, we, addr, size, uns, wd);
      #1;
      t = 0;
      while (req_ready[k] !== 1'b1 && t < 40) begin
         @(negedge clk);
         #1;
         t++;
      end
      if (t >= 40) check_val("accept_timeout", 32'd0, 32'd1);
      acc = cyc;
      t = 0;
      forever begin
         @(negedge clk);
         if (drop) req_valid[k] = 1'b0;
         #1;
         if (resp_valid[k] === 1'b1 || t >= 40) break;
         check_val("stall_wait", 32'(stall[k]), 32'(req_valid[k]));
         check_val("ready_wait", 32'(req_ready[k]), 32'd0);
         t++;
      end
      if (t >= 40) check_val("resp_timeout", 32'd0, 32'd1);
      rsp = cyc;
      rd  = resp_rdata[k];
      er  = resp_err[k];
      check_val("stall_resp", 32'(stall[k]), 32'd0);
      check_val("ready_resp", 32'(req_ready[k]), 32'd0);
      if (!hold) begin
         req_valid[k] = 1'b0;
         @(negedge clk);
         #1;
         check_val("resp_pulse", 32'(resp_valid[k]), 32'd0);
         check_val("ready_idle", 32'(req_ready[k]), 32'd1);
      end
   endtask

   task automatic run(input int k, input bit we, input logic [31:0] addr,
                      input logic [1:0] size, input bit uns, input logic [31:0] wd,
                      input bit hold, input bit drop,
                      output logic [31:0] rd, output bit er, output int acc);
      logic [31:0] exp_rd;
      bit exp_er;
      int rsp;
      model_op(k, we, addr, size, uns, wd, exp_rd, exp_er);
      xact(k, we, addr, size, uns, wd, hold, drop, rd, er, acc, rsp);
      check_val($sformatf("rdata u%0d @%h sz%0d we%0d", k, addr, size, we), rd, exp_rd);
      check_val($sformatf("err u%0d @%h sz%0d", k, addr, size), 32'(er), 32'(exp_er));
      check_val($sformatf("latency u%0d", k), 32'(rsp - acc), 32'(lat_of[k]));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      bit er;
      int a0, a1, a2;
      logic [31:0] ra;

      for (int k = 0; k < 3; k++) begin
         reset[k] = 1'b1;
         drive(k, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
         req_valid[k] = 1'b0;
      end
      repeat (3) @(negedge clk);
      for (int k = 0; k < 3; k++) reset[k] = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check_val("rst_resp_valid", 32'(resp_valid[k]), 32'd0);
         check_val("rst_rdata", resp_rdata[k], 32'd0);
         check_val("rst_err", 32'(resp_err[k]), 32'd0);
         check_val("rst_ready", 32'(req_ready[k]), 32'd1);
         check_val("rst_stall", 32'(stall[k]), 32'd0);
      end

      // Directed, LATENCY=2
      run(0, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF, 0, 0, rd, er, a0);
      check_val("sw_10_err", 32'(er), 32'd0);
      run(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("lw_10", rd, 32'hDEADBEEF);
      run(0, 0, 32'h13, 2'd0, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("lb_13", rd, 32'hFFFFFFDE);
      run(0, 0, 32'h13, 2'd0, 1, 32'h0, 0, 0, rd, er, a0);
      check_val("lbu_13", rd, 32'h000000DE);
      run(0, 0, 32'h10, 2'd1, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("lh_10", rd, 32'hFFFFBEEF);
      run(0, 0, 32'h12, 2'd1, 1, 32'h0, 0, 0, rd, er, a0);
      check_val("lhu_12", rd, 32'h0000DEAD);
      run(0, 1, 32'h11, 2'd0, 0, 32'h55, 0, 0, rd, er, a0);
      run(0, 0, 32'h10, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("sb_11", rd, 32'hDEAD55EF);
      run(0, 1, 32'h12, 2'd1, 0, 32'h1234, 0, 0, rd, er, a0);
      run(0, 0, 32'h10, 2'd2, 1, 32'h0, 0, 0, rd, er, a0);
      check_val("sh_12", rd, 32'h123455EF);
      run(0, 0, 32'h12, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("lw_12_err", 32'(er), 32'd1);
      check_val("lw_12_rdata", rd, 32'd0);
      run(0, 1, 32'h0, 2'd2, 0, 32'h0BADF00D, 0, 0, rd, er, a0);
      run(0, 1, 32'h400, 2'd2, 0, 32'hFFFFFFFF, 0, 0, rd, er, a0);
      check_val("sw_400_err", 32'(er), 32'd1);
      run(0, 0, 32'h0, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("lw_0_kept", rd, 32'h0BADF00D);
      run(0, 0, 32'h4, 2'd3, 0, 32'h0, 0, 1, rd, er, a0);
      check_val("size3_err", 32'(er), 32'd1);

      // Randomized, LATENCY=2: preload a region, then mixed accesses within and beyond it
      for (int w = 0; w < 16; w++)
         run(0, 1, 32'(w * 4), 2'd2, 0, $urandom, 0, 0, rd, er, a0);
      for (int i = 0; i < 80; i++) begin
         case ($urandom_range(0, 9))
            0:       ra = 32'h400 + $urandom_range(0, 15);
            1:       ra = 32'hFFFFFFFC + $urandom_range(0, 3);
            default: ra = $urandom_range(0, 63);
         endcase
         run(0, 1'($urandom_range(0, 1)), ra, 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, 0, 1'($urandom_range(0, 1)), rd, er, a0);
      end

      // LATENCY=4: reset while waiting drops the store
      run(1, 1, 32'h20, 2'd2, 0, 32'h11112222, 0, 0, rd, er, a0);
      run(1, 1, 32'h24, 2'd2, 0, 32'h33334444, 0, 0, rd, er, a0);
      @(negedge clk);
      drive(1, 1, 32'h20, 2'd2, 0, 32'hCAFEF00D);
      #1;
      check_val("rstw_ready", 32'(req_ready[1]), 32'd1);
      @(negedge clk);
      req_valid[1] = 1'b0;
      @(negedge clk);
      reset[1] = 1'b1;
      @(negedge clk);
      reset[1] = 1'b0;
      #1;
      check_val("rstw_ready_after", 32'(req_ready[1]), 32'd1);
      check_val("rstw_no_resp", 32'(resp_valid[1]), 32'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         check_val("rstw_no_resp_late", 32'(resp_valid[1]), 32'd0);
      end
      run(1, 0, 32'h20, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("rstw_old", rd, 32'h11112222);

      // LATENCY=4: reset landing on the response cycle
      @(negedge clk);
      drive(1, 1, 32'h24, 2'd2, 0, 32'hAAAA5555);
      @(negedge clk);
      req_valid[1] = 1'b0;
      repeat (3) @(negedge clk);
      reset[1] = 1'b1;
      #1;
      check_val("rstr_resp_gated", 32'(resp_valid[1]), 32'd0);
      @(negedge clk);
      reset[1] = 1'b0;
      #1;
      check_val("rstr_ready", 32'(req_ready[1]), 32'd1);
      run(1, 0, 32'h24, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("rstr_old", rd, 32'h33334444);

      // LATENCY=1, base 0x1000: back-to-back loads with req_valid held
      run(2, 1, 32'h1000, 2'd2, 0, 32'h01020304, 0, 0, rd, er, a0);
      run(2, 1, 32'h1004, 2'd2, 0, 32'h8899AABB, 0, 0, rd, er, a0);
      run(2, 1, 32'h1008, 2'd2, 0, 32'hF0E0D0C0, 0, 0, rd, er, a0);
      run(2, 0, 32'h1000, 2'd2, 0, 32'h0, 1, 0, rd, er, a0);
      run(2, 0, 32'h1005, 2'd0, 0, 32'h0, 1, 0, rd, er, a1);
      check_val("b2b_lb", rd, 32'hFFFFFFAA);
      run(2, 0, 32'h100A, 2'd1, 1, 32'h0, 0, 0, rd, er, a2);
      check_val("b2b_lhu", rd, 32'h0000F0E0);
      check_val("b2b_gap1", 32'(a1 - a0), 32'd2);
      check_val("b2b_gap2", 32'(a2 - a1), 32'd2);
      run(2, 0, 32'h0FFC, 2'd2, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("below_base_err", 32'(er), 32'd1);
      run(2, 1, 32'h13FC, 2'd2, 0, 32'h5A5AA5A5, 0, 0, rd, er, a0);
      run(2, 0, 32'h13FF, 2'd0, 1, 32'h0, 0, 0, rd, er, a0);
      check_val("top_byte", rd, 32'h0000005A);
      run(2, 0, 32'h1400, 2'd0, 0, 32'h0, 0, 0, rd, er, a0);
      check_val("above_top_err", 32'(er), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
